// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings, counter width
// and a small wrap-around increment helper.
`ifndef RR_ARBITER_PKG_SV
`define RR_ARBITER_PKG_SV
package rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    GAP   = ST_GAP
  } state_t;

  // Hold counter is wide enough for the largest allowed HOLD_MAX (255).
  localparam int CNT_W = 8;

  // (v + 1) mod n for 0 <= v < n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`endif

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
  parameter int N = 4
) ();

  logic [N-1:0]         req;
  logic                 done;
  logic [N-1:0]         gnt;
  logic                 busy;
  logic [$clog2(N)-1:0] owner;
  logic                 timeout;

  modport master (
    output req, done,
    input  gnt, busy, owner, timeout
  );

  modport slave (
    input  req, done,
    output gnt, busy, owner, timeout
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Rotating-priority selector: first asserted request at or above the pointer,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_index
);

  localparam int IW = $clog2(N);

  // Walk the N positions starting at the pointer and latch the first hit.
  always_comb begin
    int k;
    o_valid = 1'b0;
    o_index = '0;
    k       = int'(i_ptr);
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[IW'(k)]) begin
        o_valid = 1'b1;
        o_index = IW'(k);
      end
      k = wrap_inc(k, N);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded hold time. One owner at a time; a grant ends
// on done, on the owner dropping its request, or when the hold limit is hit
// (forced release, flagged by a one-cycle timeout pulse). Every grant is
// followed by a single dead GAP cycle before requests are sampled again.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic       C,
  input  logic       R,
  rr_arbiter_if.slave bus
);

  localparam int             IW      = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  state_t           r_state,   w_state_nxt;
  logic [N-1:0]     r_gnt,     w_gnt_nxt;
  logic             r_busy,    w_busy_nxt;
  logic [IW-1:0]    r_owner,   w_owner_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [IW-1:0]    r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;

  logic             w_valid;
  logic [IW-1:0]    w_idx;
  logic             w_own_req;
  logic             w_limit;
  logic             w_release;

  rr_pick #(.N(N)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_index (w_idx)
  );

  assign w_own_req = bus.req[r_owner];
  assign w_limit   = (r_cnt == CNT_LIM);
  assign w_release = bus.done || !w_own_req || w_limit;

  // State register.
  always_ff @(posedge C or posedge R) begin
    if (R) r_state <= IDLE;
    else   r_state <= w_state_nxt;
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_busy_nxt    = r_busy;
    w_owner_nxt   = r_owner;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt        = GRANT;
          w_gnt_nxt          = '0;
          w_gnt_nxt[w_idx]   = 1'b1;
          w_busy_nxt         = 1'b1;
          w_owner_nxt        = w_idx;
          w_ptr_nxt          = IW'(wrap_inc(int'(w_idx), N));
          w_cnt_nxt          = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt   = GAP;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          // Only a pure limit release is a timeout; done wins a tie.
          w_timeout_nxt = w_limit && !bus.done && w_own_req;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs, rotation pointer and hold counter.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_owner   <= w_owner_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.owner   = r_owner;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, HOLD_MAX=16) with hand-computed results.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 16;

  logic C;
  logic R;
  int   n_chk;
  int   n_err;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge C);
    @(negedge C);
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.done = 1'b0;
    R = 1'b1;
    step();
    R = 1'b0;
  endtask

  // gnt must be one-hot or zero at every sample point.
  always @(negedge C) begin
    if (!R) check("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    int exp_b[5];
    n_chk    = 0;
    n_err    = 0;
    R        = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #2 R = 1'b1;
    @(negedge C);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_owner", int'(bus.owner), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    R = 1'b0;

    // req=0101 held, done once per grant: 0,2,0,2
    exp_a = '{0, 2, 0, 2};
    bus.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_gnt", int'(bus.gnt), 1 << exp_a[i]);
      check("t1_busy", int'(bus.busy), 1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check("t1_gap_gnt", int'(bus.gnt), 0);
      check("t1_gap_busy", int'(bus.busy), 0);
      check("t1_gap_to", int'(bus.timeout), 0);
      check("t1_gap_owner", int'(bus.owner), exp_a[i]);
      step();
      check("t1_idle_gnt", int'(bus.gnt), 0);
    end

    // idle with no requests, then req=1111 -> 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_idle_gnt", int'(bus.gnt), 0);
      check("t2_idle_busy", int'(bus.busy), 0);
    end
    exp_b = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_gnt", int'(bus.gnt), 1 << exp_b[i]);
      check("t2_owner", int'(bus.owner), exp_b[i]);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check("t2_gap_gnt", int'(bus.gnt), 0);
      check("t2_gap_to", int'(bus.timeout), 0);
      step();
    end

    // req=0010, done=0: 16 grant cycles, timeout pulse, GAP, re-grant
    do_reset();
    bus.req = 4'b0010;
    step();
    check("t3_gnt_first", int'(bus.gnt), 2);
    for (int i = 1; i < HOLD_MAX; i++) begin
      step();
      check("t3_gnt_hold", int'(bus.gnt), 2);
      check("t3_to_hold", int'(bus.timeout), 0);
    end
    step();
    check("t3_rel_gnt", int'(bus.gnt), 0);
    check("t3_rel_busy", int'(bus.busy), 0);
    check("t3_rel_to", int'(bus.timeout), 1);
    step();
    check("t3_idle_to", int'(bus.timeout), 0);
    check("t3_idle_gnt", int'(bus.gnt), 0);
    step();
    check("t3_regrant", int'(bus.gnt), 2);
    check("t3_regrant_owner", int'(bus.owner), 1);
    bus.req = '0;
    step();
    check("t3_drop_gnt", int'(bus.gnt), 0);
    check("t3_drop_to", int'(bus.timeout), 0);

    // owner 0 drops its request while 3 waits
    do_reset();
    bus.req = 4'b0001;
    step();
    check("t4_gnt0", int'(bus.gnt), 1);
    bus.req = 4'b1001;
    step();
    check("t4_ignore_other", int'(bus.gnt), 1);
    bus.req = 4'b1000;
    step();
    check("t4_gap_gnt", int'(bus.gnt), 0);
    check("t4_gap_to", int'(bus.timeout), 0);
    step();
    check("t4_idle_gnt", int'(bus.gnt), 0);
    step();
    check("t4_gnt3", int'(bus.gnt), 8);
    check("t4_owner3", int'(bus.owner), 3);

    // asynchronous reset mid-grant
    do_reset();
    bus.req = 4'b0100;
    step();
    check("t5_gnt2", int'(bus.gnt), 4);
    check("t5_owner2", int'(bus.owner), 2);
    #2 R = 1'b1;
    #1;
    check("t5_arst_gnt", int'(bus.gnt), 0);
    check("t5_arst_busy", int'(bus.busy), 0);
    check("t5_arst_owner", int'(bus.owner), 0);
    check("t5_arst_to", int'(bus.timeout), 0);
    #1 R = 1'b0;
    bus.req = 4'b1000;
    step();
    check("t5_gnt3", int'(bus.gnt), 8);
    check("t5_owner3", int'(bus.owner), 3);
    check("t5_to", int'(bus.timeout), 0);

    // done coincides with the hold limit
    do_reset();
    bus.req = 4'b0010;
    step();
    for (int i = 1; i < HOLD_MAX; i++) begin
      step();
      check("t6_gnt_hold", int'(bus.gnt), 2);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("t6_rel_gnt", int'(bus.gnt), 0);
    check("t6_rel_to", int'(bus.timeout), 0);
    step();
    check("t6_idle_gnt", int'(bus.gnt), 0);
    check("t6_idle_to", int'(bus.timeout), 0);
    step();
    check("t6_regrant", int'(bus.gnt), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
